// File: rtl/hdu_fwd.sv
// Decode-stage hazard detection and forwarding-select unit: tracks recent producers, picks youngest forwarding source.
// Optional load-use stall enabled by defining HDU_FWD_LOAD_STALL_EN.
module hdu_fwd #(
    parameter  int REG_ADDRESS_LENGTH = 5,
    parameter  int FWD_DEPTH          = 3,
    localparam int SEL_W              = $clog2(FWD_DEPTH + 1)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          issue_valid,
    input  logic [REG_ADDRESS_LENGTH-1:0] issue_ra,
    input  logic [REG_ADDRESS_LENGTH-1:0] issue_rb,
    input  logic                          issue_use_ra,
    input  logic                          issue_use_rb,
    input  logic [REG_ADDRESS_LENGTH-1:0] issue_rd,
    input  logic                          issue_wr_en,
    input  logic                          issue_is_load,
    input  logic                          flush,
    output logic [SEL_W-1:0]              fwd_sel_a,
    output logic [SEL_W-1:0]              fwd_sel_b,
    output logic                          stall
);

    logic [FWD_DEPTH-1:0]                         r_vld, r_wr;
    logic [FWD_DEPTH-1:0][REG_ADDRESS_LENGTH-1:0] r_rd;
    logic [FWD_DEPTH-1:0]                         w_vld_nxt, w_wr_nxt;
    logic [FWD_DEPTH-1:0][REG_ADDRESS_LENGTH-1:0] w_rd_nxt;
    logic [FWD_DEPTH-1:0]                         w_hit_a, w_hit_b;
    logic [SEL_W-1:0]                             w_sel_a, w_sel_b;
    logic                                         w_stall, w_acc, w_gate;

    assign w_acc  = issue_valid & ~w_stall & ~flush;
    assign w_gate = issue_valid & ~w_stall & ~flush;

    generate
        if (FWD_DEPTH > 1) begin : g_chain
            assign w_vld_nxt = flush ? '0 : {r_vld[FWD_DEPTH-2:0], w_acc};
            assign w_wr_nxt  = {r_wr[FWD_DEPTH-2:0], issue_wr_en};
            assign w_rd_nxt  = {r_rd[FWD_DEPTH-2:0], issue_rd};
        end else begin : g_single
            assign w_vld_nxt = w_acc;
            assign w_wr_nxt  = issue_wr_en;
            assign w_rd_nxt  = issue_rd;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld <= '0;
            r_wr  <= '0;
            r_rd  <= '0;
        end else begin
            r_vld <= w_vld_nxt;
            r_wr  <= w_wr_nxt;
            r_rd  <= w_rd_nxt;
        end
    end

    // Register 0 is hardwired, so it never counts as a producer.
    always_comb begin
        for (int k = 0; k < FWD_DEPTH; k++) begin
            w_hit_a[k] = r_vld[k] & r_wr[k] & (r_rd[k] == issue_ra) & (issue_ra != '0);
            w_hit_b[k] = r_vld[k] & r_wr[k] & (r_rd[k] == issue_rb) & (issue_rb != '0);
        end
    end

    // Scan oldest to youngest so the youngest hit overwrites.
    always_comb begin
        w_sel_a = '0;
        w_sel_b = '0;
        for (int k = FWD_DEPTH - 1; k >= 0; k--) begin
            if (w_hit_a[k]) w_sel_a = SEL_W'(k + 1);
            if (w_hit_b[k]) w_sel_b = SEL_W'(k + 1);
        end
    end

    assign fwd_sel_a = (w_gate & issue_use_ra) ? w_sel_a : '0;
    assign fwd_sel_b = (w_gate & issue_use_rb) ? w_sel_b : '0;

`ifdef HDU_FWD_LOAD_STALL_EN
    logic [FWD_DEPTH-1:0] r_ld, w_ld_nxt;

    generate
        if (FWD_DEPTH > 1) begin : g_ld_chain
            assign w_ld_nxt = {r_ld[FWD_DEPTH-2:0], issue_is_load};
        end else begin : g_ld_single
            assign w_ld_nxt = issue_is_load;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_ld <= '0;
        else        r_ld <= w_ld_nxt;
    end

    // A load result is not ready one cycle after issue; the consumer waits one slot.
    assign w_stall = issue_valid & ~flush & r_ld[0] &
                     ((w_hit_a[0] & issue_use_ra) | (w_hit_b[0] & issue_use_rb));
`else
    logic w_unused;
    assign w_unused = issue_is_load;
    assign w_stall  = 1'b0;
`endif

    assign stall = w_stall;

endmodule

// File: tb/tb_hdu_fwd.sv
// Randomized and directed bench for hdu_fwd against a history-based reference model.
module tb_hdu_fwd;
    localparam int RA = 5;
    localparam int D  = 3;
    localparam int SW = $clog2(D + 1);

    logic          clk, rst_n;
    logic          issue_valid, issue_use_ra, issue_use_rb, issue_wr_en, issue_is_load, flush;
    logic [RA-1:0] issue_ra, issue_rb, issue_rd;
    logic [SW-1:0] fwd_sel_a, fwd_sel_b;
    logic          stall;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: what was accepted k+1 cycles ago (index 0 = previous cycle).
    int  h_rd [D];
    bit  h_v  [D];
    bit  h_wr [D];
    bit  h_ld [D];

    hdu_fwd #(.REG_ADDRESS_LENGTH(RA), .FWD_DEPTH(D)) dut (
        .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid),
        .issue_ra(issue_ra), .issue_rb(issue_rb),
        .issue_use_ra(issue_use_ra), .issue_use_rb(issue_use_rb),
        .issue_rd(issue_rd), .issue_wr_en(issue_wr_en), .issue_is_load(issue_is_load),
        .flush(flush), .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b), .stall(stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit m_stall();
`ifdef HDU_FWD_LOAD_STALL_EN
        if (!rst_n || !issue_valid || flush) return 1'b0;
        if (!(h_v[0] && h_wr[0] && h_ld[0])) return 1'b0;
        if (issue_use_ra && int'(issue_ra) == h_rd[0] && issue_ra != 0) return 1'b1;
        if (issue_use_rb && int'(issue_rb) == h_rd[0] && issue_rb != 0) return 1'b1;
        return 1'b0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic int m_sel(int addr, bit use_it);
        if (!rst_n || !issue_valid || !use_it || flush || m_stall()) return 0;
        if (addr == 0) return 0;
        for (int k = 0; k < D; k++)
            if (h_v[k] && h_wr[k] && h_rd[k] == addr) return k + 1;
        return 0;
    endfunction

    task automatic m_clear();
        for (int k = 0; k < D; k++) begin
            h_v[k] = 0; h_wr[k] = 0; h_ld[k] = 0; h_rd[k] = 0;
        end
    endtask

    task automatic cmp(string nm, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_model();
        cmp("model_sel_a", int'(fwd_sel_a), m_sel(int'(issue_ra), issue_use_ra));
        cmp("model_sel_b", int'(fwd_sel_b), m_sel(int'(issue_rb), issue_use_rb));
        cmp("model_stall", int'(stall), int'(m_stall()));
    endtask

    task automatic drv(bit v, int ra, int rb, bit ua, bit ub, int rd, bit wr, bit ld, bit fl);
        issue_valid = v; issue_ra = RA'(ra); issue_rb = RA'(rb);
        issue_use_ra = ua; issue_use_rb = ub; issue_rd = RA'(rd);
        issue_wr_en = wr; issue_is_load = ld; flush = fl;
        #1;
        check_model();
    endtask

    task automatic bubble();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic adv();
        bit acc;
        @(posedge clk);
        acc = rst_n && issue_valid && !flush && !m_stall();
        for (int k = D - 1; k > 0; k--) begin
            h_v[k] = flush ? 1'b0 : h_v[k-1];
            h_wr[k] = h_wr[k-1]; h_ld[k] = h_ld[k-1]; h_rd[k] = h_rd[k-1];
        end
        h_v[0] = acc; h_wr[0] = issue_wr_en; h_ld[0] = issue_is_load; h_rd[0] = int'(issue_rd);
        if (!rst_n) m_clear();
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        m_clear();
        drv(1, 5, 5, 1, 1, 5, 1, 0, 0);
        cmp("reset_sel_a", int'(fwd_sel_a), 0);
        cmp("reset_stall", int'(stall), 0);
        @(negedge clk); adv();
        rst_n = 1'b1;

        // Single-cycle-old producer
        drv(1, 0, 0, 0, 0, 5, 1, 0, 0); adv();
        drv(1, 5, 0, 1, 0, 0, 0, 0, 0);
        cmp("r031_sel_a", int'(fwd_sel_a), 1);
        cmp("r031_sel_b", int'(fwd_sel_b), 0);
        adv();

        // Oldest tracked entry, then out of reach
        drv(1, 0, 0, 0, 0, 7, 1, 0, 0); adv();
        bubble(); adv(); bubble(); adv();
        drv(1, 7, 0, 1, 0, 0, 0, 0, 0);
        cmp("r032_sel_a_3", int'(fwd_sel_a), 3);
        adv();
        drv(1, 0, 0, 0, 0, 7, 1, 0, 0); adv();
        bubble(); adv(); bubble(); adv(); bubble(); adv();
        drv(1, 7, 0, 1, 0, 0, 0, 0, 0);
        cmp("r032_sel_a_0", int'(fwd_sel_a), 0);
        adv();

        // Youngest wins
        drv(1, 0, 0, 0, 0, 4, 1, 0, 0); adv();
        drv(1, 0, 0, 0, 0, 4, 1, 0, 0); adv();
        drv(1, 4, 4, 1, 1, 0, 0, 0, 0);
        cmp("r033_sel_a", int'(fwd_sel_a), 1);
        cmp("r033_sel_b", int'(fwd_sel_b), 1);
        adv();

        // r0 and non-writing instructions never forward
        drv(1, 0, 0, 0, 0, 0, 1, 0, 0); adv();
        drv(1, 0, 0, 1, 0, 0, 0, 0, 0);
        cmp("r034_r0", int'(fwd_sel_a), 0);
        adv();
        drv(1, 0, 0, 0, 0, 3, 0, 0, 0); adv();
        drv(1, 3, 0, 1, 0, 0, 0, 0, 0);
        cmp("r034_nowr", int'(fwd_sel_a), 0);
        adv();

        // Load-use
        drv(1, 0, 0, 0, 0, 9, 1, 1, 0); adv();
        drv(1, 0, 9, 0, 1, 0, 0, 0, 0);
`ifdef HDU_FWD_LOAD_STALL_EN
        cmp("r035_stall", int'(stall), 1);
        cmp("r035_sel_b0", int'(fwd_sel_b), 0);
        adv();
        drv(1, 0, 9, 0, 1, 0, 0, 0, 0);
        cmp("r035_restall", int'(stall), 0);
        cmp("r035_sel_b2", int'(fwd_sel_b), 2);
`else
        cmp("r035_stall", int'(stall), 0);
        cmp("r035_sel_b1", int'(fwd_sel_b), 1);
`endif
        adv();

        // Flush
        drv(1, 0, 0, 0, 0, 6, 1, 0, 0); adv();
        drv(1, 6, 6, 1, 1, 0, 0, 0, 1);
        cmp("r036_fl_sel_a", int'(fwd_sel_a), 0);
        cmp("r036_fl_stall", int'(stall), 0);
        adv();
        drv(1, 6, 0, 1, 0, 0, 0, 0, 0);
        cmp("r036_post_fl", int'(fwd_sel_a), 0);
        adv();

        // Reset mid-operation
        drv(1, 0, 0, 0, 0, 8, 1, 0, 0); adv();
        drv(1, 8, 8, 1, 1, 0, 0, 0, 0);
        cmp("rst_pre_sel_a", int'(fwd_sel_a), 1);
        rst_n = 1'b0;
        #1;
        m_clear();
        cmp("rst_mid_sel_a", int'(fwd_sel_a), 0);
        cmp("rst_mid_sel_b", int'(fwd_sel_b), 0);
        cmp("rst_mid_stall", int'(stall), 0);
        adv();
        rst_n = 1'b1;
        drv(1, 8, 8, 1, 1, 0, 0, 0, 0);
        cmp("rst_post_sel_a", int'(fwd_sel_a), 0);
        adv();

        // Random traffic, small address space to provoke hits
        for (int i = 0; i < 600; i++) begin
            drv($urandom_range(3, 0) != 0, $urandom_range(7, 0), $urandom_range(7, 0),
                $urandom_range(1, 0) == 1, $urandom_range(1, 0) == 1, $urandom_range(7, 0),
                $urandom_range(3, 0) != 0, $urandom_range(2, 0) == 0, $urandom_range(15, 0) == 0);
            adv();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/hdu_fwd.md
HDU_FWD -- requirements
Module: hdu_fwd

Interface
REQ-001 SHALL have parameter REG_ADDRESS_LENGTH, default 5, register address width.
REQ-002 SHALL have parameter FWD_DEPTH, default 3, number of tracked in-flight producer stages; legal range 1..7.
REQ-003 SHALL derive localparam SEL_W = clog2(FWD_DEPTH+1), the forward-select width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 issue_valid  input  1  an instruction is presented at decode this cycle.
REQ-007 issue_ra, issue_rb  input  REG_ADDRESS_LENGTH each  source register addresses.
REQ-008 issue_use_ra, issue_use_rb  input  1 each  the source operand is actually read.
REQ-009 issue_rd  input  REG_ADDRESS_LENGTH  destination register address.
REQ-010 issue_wr_en  input  1  the instruction writes issue_rd.
REQ-011 issue_is_load  input  1  the instruction is a load (result is late).
REQ-012 flush  input  1  synchronous pipeline flush.
REQ-013 fwd_sel_a, fwd_sel_b  output  SEL_W each  0 = register file, k = forward from tracked stage k-1.
REQ-014 stall  output  1  hold decode and insert a bubble this cycle.

Function
REQ-015 SHALL hold a tracking shift register of FWD_DEPTH entries {valid, rd, wr_en, is_load}; entry 0 is the youngest (instruction issued in the previous cycle).
REQ-016 Each rising edge, entries 1..FWD_DEPTH-1 SHALL load from the next-younger entry, and the oldest entry SHALL be discarded.
REQ-017 Entry 0 SHALL load {1, issue_rd, issue_wr_en, issue_is_load} when issue_valid=1 and stall=0; otherwise it SHALL load a bubble (valid=0).
REQ-018 An entry SHALL be a producer for address X only when valid=1, wr_en=1, rd==X and X!=0.
REQ-019 fwd_sel_a SHALL be combinational: k+1 for the lowest-index entry k that produces issue_ra, else 0; forced to 0 when issue_use_ra=0 or issue_valid=0.
REQ-020 fwd_sel_b SHALL follow REQ-019 using issue_rb and issue_use_rb.
REQ-021 Youngest-match priority SHALL apply when multiple entries write the same address.
REQ-022 Forwarding latency SHALL be 0 cycles: selects reflect the entries and issue inputs of the current cycle.
REQ-023 When stall=1, fwd_sel_a and fwd_sel_b SHALL both be 0.
REQ-024 flush=1 SHALL clear valid in all entries at the next edge, overriding REQ-017, and SHALL force stall=0 and both selects to 0 in the same cycle.
REQ-025 With FWD_DEPTH=1 the block SHALL track only entry 0, with no shift chain.

Reset
REQ-026 While rst_n=0, all entry valid bits SHALL be 0, and stall, fwd_sel_a and fwd_sel_b SHALL read 0.
REQ-027 Reset asserted mid-operation SHALL drop all tracked producers immediately; the first issue after release SHALL see no forwarding.

Configuration
REQ-028 Macro HDU_FWD_LOAD_STALL_EN defined: stall=1 when issue_valid=1, flush=0 and entry 0 is a load producer of a used source (issue_ra with issue_use_ra, or issue_rb with issue_use_rb).
REQ-029 With HDU_FWD_LOAD_STALL_EN defined, a stalled instruction SHALL be re-presented next cycle; the load has then moved to entry 1 and is forwarded with select 2.
REQ-030 Macro HDU_FWD_LOAD_STALL_EN undefined: stall SHALL be tied 0, is_load storage SHALL be removed, and load producers SHALL forward like any other producer.

Verification
REQ-031 Issue rd=5 wr_en=1, next cycle issue ra=5 use_ra=1 -> fwd_sel_a=1, fwd_sel_b=0.
REQ-032 Issue rd=7, two bubbles, then ra=7 (FWD_DEPTH=3) -> fwd_sel_a=3; one more bubble before the read -> fwd_sel_a=0.
REQ-033 Issue rd=4, then rd=4 again, then ra=4 rb=4 -> fwd_sel_a=fwd_sel_b=1 (youngest match wins).
REQ-034 Issue rd=0 wr_en=1, then ra=0 -> fwd_sel_a=0; issue rd=3 wr_en=0, then ra=3 -> fwd_sel_a=0.
REQ-035 With HDU_FWD_LOAD_STALL_EN: load rd=9, then rb=9 use_rb=1 -> stall=1 and selects 0 for one cycle; the re-presented rb=9 gives stall=0 and fwd_sel_b=2. Without the macro: stall=0, fwd_sel_b=1.
REQ-036 Issue rd=6, then assert flush with ra=6 -> selects 0 and stall=0 that cycle; ra=6 next cycle -> fwd_sel_a=0. Also drive rst_n=0 between cycles with pending producers -> outputs 0 immediately.
